// File: rtl/square_move_receiver.sv
// square_move_receiver
// Receiving end of the ray/knight token broadcast for one board square.
// A capture strobe latches all incoming tokens and the square's contents,
// decides which tokens are legal moves onto this square, and then streams
// those moves one per valid/ready handshake, lowest candidate index first.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   engine_color         side to move (1 = white)
//   capture              single-cycle strobe: latch inputs, start a scan
//   sq_piece[5:0]        this square's contents {colour, type}
//   in_<ray>[10:0]       ray tokens {colour, type[3:0], origin[5:0]}
//   in_<knight>[7:0]     knight tokens {colour, present, origin[5:0]}
//   move_valid/ready     move handshake
//   move_from/to/piece   presented move; move_to is always SQ
//   move_capture         target held an enemy piece at capture time
//   busy, done           scan in progress / one-cycle end-of-scan pulse
//
// state | meaning
// IDLE  | waiting for capture
// SCAN  | presenting latched legal moves, lowest index first
// DONE  | one-cycle done pulse, then back to IDLE
module square_move_receiver #(
  parameter logic [5:0] SQ = 6'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        engine_color,
  input  logic        capture,
  input  logic [5:0]  sq_piece,
  input  logic [10:0] in_u,
  input  logic [10:0] in_d,
  input  logic [10:0] in_l,
  input  logic [10:0] in_r,
  input  logic [10:0] in_ul,
  input  logic [10:0] in_ur,
  input  logic [10:0] in_dl,
  input  logic [10:0] in_dr,
  input  logic [7:0]  in_uul,
  input  logic [7:0]  in_uur,
  input  logic [7:0]  in_llu,
  input  logic [7:0]  in_rru,
  input  logic [7:0]  in_ddl,
  input  logic [7:0]  in_ddr,
  input  logic [7:0]  in_lld,
  input  logic [7:0]  in_rrd,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic [4:0]  move_piece,
  output logic        move_capture,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] T_ROOK   = 4'b1000;
  localparam logic [3:0] T_QUEEN  = 4'b1100;
  localparam logic [3:0] T_BISHOP = 4'b0100;
  localparam logic [3:0] T_KING   = 4'b0010;
  localparam logic [3:0] T_PAWN   = 4'b0001;

  localparam logic [2:0] DIR_U  = 3'd0;
  localparam logic [2:0] DIR_D  = 3'd1;
  localparam logic [2:0] DIR_UL = 3'd4;
  localparam logic [2:0] DIR_UR = 3'd5;
  localparam logic [2:0] DIR_DL = 3'd6;
  localparam logic [2:0] DIR_DR = 3'd7;

  logic [10:0] ray [8];
  logic [7:0]  knt [8];

  assign ray[0] = in_u;
  assign ray[1] = in_d;
  assign ray[2] = in_l;
  assign ray[3] = in_r;
  assign ray[4] = in_ul;
  assign ray[5] = in_ur;
  assign ray[6] = in_dl;
  assign ray[7] = in_dr;
  assign knt[0] = in_uul;
  assign knt[1] = in_uur;
  assign knt[2] = in_llu;
  assign knt[3] = in_rru;
  assign knt[4] = in_ddl;
  assign knt[5] = in_ddr;
  assign knt[6] = in_lld;
  assign knt[7] = in_rrd;

  logic sq_empty, sq_enemy, target_ok;
  assign sq_empty  = (sq_piece[4:0] == 5'd0);
  assign sq_enemy  = !sq_empty && (sq_piece[5] != engine_color);
  assign target_ok = sq_empty || sq_enemy;

  // 4-bit two's complement difference in {-1, 0, +1}
  function automatic logic near1(input logic [3:0] d);
    return (d == 4'd0) || (d == 4'd1) || (d == 4'hF);
  endfunction

  function automatic logic ray_ok(input logic [10:0] tok, input logic [2:0] dir,
                                  input logic col, input logic empty,
                                  input logic enemy, input logic tgt_ok);
    logic [3:0] d_rank, d_file;
    logic       ortho, pawn_ok, type_ok;
    d_rank = {1'b0, tok[5:3]} - {1'b0, SQ[5:3]};
    d_file = {1'b0, tok[2:0]} - {1'b0, SQ[2:0]};
    ortho  = (dir < 3'd4);
    // pawn colour equals the side to move once the colour check passes
    if (tok[10])
      pawn_ok = (d_rank == 4'hF) &&
                ((dir == DIR_U && empty) || ((dir == DIR_UL || dir == DIR_UR) && enemy));
    else
      pawn_ok = (d_rank == 4'd1) &&
                ((dir == DIR_D && empty) || ((dir == DIR_DL || dir == DIR_DR) && enemy));
    case (tok[9:6])
      T_ROOK:   type_ok = ortho;
      T_BISHOP: type_ok = !ortho;
      T_QUEEN:  type_ok = 1'b1;
      T_KING:   type_ok = near1(d_rank) && near1(d_file);
      T_PAWN:   type_ok = pawn_ok;
      default:  type_ok = 1'b0;
    endcase
    return type_ok && (tok[10] == col) && tgt_ok;
  endfunction

  logic [15:0] legal;
  logic [5:0]  org_d [16];
  logic [4:0]  piece_d [16];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      legal[i]       = ray_ok(ray[i], 3'(i), engine_color, sq_empty, sq_enemy, target_ok);
      legal[8+i]     = knt[i][6] && (knt[i][7] == engine_color) && target_ok;
      org_d[i]       = ray[i][5:0];
      org_d[8+i]     = knt[i][5:0];
      piece_d[i]     = ray[i][10:6];
      piece_d[8+i]   = {knt[i][7], 4'b0000};
    end
  end

  logic [1:0]  state;
  logic [15:0] mask_q;
  logic [5:0]  org_q [16];
  logic [4:0]  piece_q [16];
  logic        cap_q;
  logic [3:0]  sel;
  logic [15:0] mask_clr;

  // lowest set bit wins; scanning downward leaves it as the final assignment
  always_comb begin
    sel = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) sel = 4'(i);
    end
  end

  assign mask_clr = mask_q & ~(16'd1 << sel);

  // outputs are forced to their idle values outside SCAN so reset and
  // post-scan values match without extra output registers
  assign move_valid   = (state == ST_SCAN);
  assign busy         = (state == ST_SCAN);
  assign done         = (state == ST_DONE);
  assign move_to      = SQ;
  assign move_from    = move_valid ? org_q[sel]   : 6'd0;
  assign move_piece   = move_valid ? piece_q[sel] : 5'd0;
  assign move_capture = move_valid ? cap_q        : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      mask_q <= 16'd0;
      cap_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        org_q[i]   <= 6'd0;
        piece_q[i] <= 5'd0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            mask_q  <= legal;
            org_q   <= org_d;
            piece_q <= piece_d;
            cap_q   <= sq_enemy;
            state   <= (legal != 16'd0) ? ST_SCAN : ST_DONE;
          end
        end
        ST_SCAN: begin
          if (move_ready) begin
            mask_q <= mask_clr;
            if (mask_clr == 16'd0) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_move_receiver.sv
// tb_square_move_receiver
// Self-checking bench for square_move_receiver at SQ = 6'o34. Directed
// scenarios plus randomized captures checked against a move-list model
// built from the legality rules with plain integer board arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_square_move_receiver;

  localparam logic [5:0] TB_SQ = 6'o34;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        engine_color;
  logic        capture;
  logic [5:0]  sq_piece;
  logic [10:0] ray_tok [8];
  logic [7:0]  kn_tok [8];
  logic        move_valid, move_ready, move_capture, busy, done;
  logic [5:0]  move_from, move_to;
  logic [4:0]  move_piece;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] org;
    logic [4:0] piece;
    logic       cap;
  } move_t;
  move_t exp_q[$];

  always #5 clk = ~clk;

  square_move_receiver #(.SQ(TB_SQ)) dut (
    .clk(clk), .reset_n(reset_n), .engine_color(engine_color), .capture(capture),
    .sq_piece(sq_piece),
    .in_u(ray_tok[0]), .in_d(ray_tok[1]), .in_l(ray_tok[2]), .in_r(ray_tok[3]),
    .in_ul(ray_tok[4]), .in_ur(ray_tok[5]), .in_dl(ray_tok[6]), .in_dr(ray_tok[7]),
    .in_uul(kn_tok[0]), .in_uur(kn_tok[1]), .in_llu(kn_tok[2]), .in_rru(kn_tok[3]),
    .in_ddl(kn_tok[4]), .in_ddr(kn_tok[5]), .in_lld(kn_tok[6]), .in_rrd(kn_tok[7]),
    .move_valid(move_valid), .move_ready(move_ready), .move_from(move_from),
    .move_to(move_to), .move_piece(move_piece), .move_capture(move_capture),
    .busy(busy), .done(done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic clear_inputs();
    for (int i = 0; i < 8; i++) begin
      ray_tok[i] = 11'd0;
      kn_tok[i]  = 8'd0;
    end
    sq_piece     = 6'd0;
    engine_color = 1'b1;
    capture      = 1'b0;
    move_ready   = 1'b0;
  endtask

  // returns on the falling edge of the cycle after capture was sampled
  task automatic pulse_capture();
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
  endtask

  // expected move list in priority order, from the legality rules
  task automatic model_build();
    logic [5:0] sqv;
    int sr, sf, orank, ofile, dr, df;
    bit empty, enemy, ok;
    logic [10:0] t;
    logic [7:0] k;
    sqv   = TB_SQ;
    sr    = int'(sqv[5:3]);
    sf    = int'(sqv[2:0]);
    empty = (sq_piece[4:0] == 5'd0);
    enemy = !empty && (sq_piece[5] != engine_color);
    exp_q.delete();
    for (int d = 0; d < 8; d++) begin
      t = ray_tok[d];
      orank = int'(t[5:3]);
      ofile = int'(t[2:0]);
      dr = orank - sr;
      df = ofile - sf;
      ok = 0;
      if (t[9:6] != 4'd0 && t[10] == engine_color && (empty || enemy)) begin
        case (t[9:6])
          4'b1000: ok = (d < 4);
          4'b0100: ok = (d >= 4);
          4'b1100: ok = 1;
          4'b0010: ok = ((dr < 0 ? -dr : dr) <= 1) && ((df < 0 ? -df : df) <= 1);
          4'b0001: begin
            if (t[10]) ok = (orank == sr - 1) && ((d == 0 && empty) || ((d == 4 || d == 5) && enemy));
            else       ok = (orank == sr + 1) && ((d == 1 && empty) || ((d == 6 || d == 7) && enemy));
          end
          default: ok = 0;
        endcase
      end
      if (ok) exp_q.push_back('{t[5:0], t[10:6], enemy});
    end
    for (int n = 0; n < 8; n++) begin
      k = kn_tok[n];
      if (k[6] && k[7] == engine_color && (empty || enemy))
        exp_q.push_back('{k[5:0], {k[7], 4'b0000}, enemy});
    end
  endtask

  function automatic logic [5:0] rand_origin();
    logic [2:0] r, f;
    if ($urandom_range(1) == 1) begin
      r = 3'(3 + $urandom_range(2) - 1);
      f = 3'(4 + $urandom_range(2) - 1);
    end else begin
      r = 3'($urandom);
      f = 3'($urandom);
    end
    return {r, f};
  endfunction

  task automatic randomize_inputs();
    logic [3:0] types [7];
    types[0] = 4'b0000; types[1] = 4'b1000; types[2] = 4'b1100; types[3] = 4'b0100;
    types[4] = 4'b0010; types[5] = 4'b0001; types[6] = 4'($urandom);
    case ($urandom_range(2))
      0:       sq_piece = 6'd0;
      default: sq_piece = {1'($urandom), 5'($urandom_range(31, 1))};
    endcase
    for (int i = 0; i < 8; i++) begin
      ray_tok[i] = {($urandom_range(3) == 0) ? ~engine_color : engine_color,
                    types[$urandom_range(6)], rand_origin()};
      kn_tok[i]  = {($urandom_range(3) == 0) ? ~engine_color : engine_color,
                    1'($urandom), 6'($urandom)};
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({move_valid, move_from, move_to, move_piece, move_capture, busy, done} !==
        {1'b0, 6'd0, TB_SQ, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h",
               {move_valid, move_from, move_to, move_piece, move_capture, busy, done},
               {1'b0, 6'd0, TB_SQ, 5'd0, 1'b0, 1'b0, 1'b0});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({move_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got v/busy/done=%b want 000", {move_valid, busy, done});
    end
  endtask

  task automatic test_rook_knight();
    clear_inputs();
    ray_tok[0] = {1'b1, 4'b1000, 6'o04};
    kn_tok[0]  = {1'b1, 1'b1, 6'o15};
    move_ready = 1'b1;
    pulse_capture();
    checks++;
    if ({move_valid, move_from, move_piece, move_capture, busy, done} !==
        {1'b1, 6'o04, 5'b11000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rook_move: got v=%0b from=%o piece=%b cap=%0b busy=%0b done=%0b want 1 04 11000 0 1 0",
               move_valid, move_from, move_piece, move_capture, busy, done);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, move_from, move_piece, move_capture} !== {1'b1, 6'o15, 5'b10000, 1'b0}) begin
      errors++;
      $display("FAIL knight_move: got v=%0b from=%o piece=%b cap=%0b want 1 15 10000 0",
               move_valid, move_from, move_piece, move_capture);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL rook_knight_done: got v/busy/done=%b want 001", {move_valid, busy, done});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%0b want 0", done);
    end
  endtask

  task automatic test_pawn_capture();
    clear_inputs();
    sq_piece   = {1'b0, 5'b00001};
    ray_tok[0] = {1'b1, 4'b0001, 6'o24};
    ray_tok[4] = {1'b1, 4'b0001, 6'o25};
    move_ready = 1'b1;
    pulse_capture();
    checks++;
    if ({move_valid, move_from, move_piece, move_capture} !== {1'b1, 6'o25, 5'b10001, 1'b1}) begin
      errors++;
      $display("FAIL pawn_capture: got v=%0b from=%o piece=%b cap=%0b want 1 25 10001 1",
               move_valid, move_from, move_piece, move_capture);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, done} !== 2'b01) begin
      errors++;
      $display("FAIL pawn_done: got v/done=%b want 01", {move_valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_king();
    clear_inputs();
    ray_tok[3] = {1'b1, 4'b0010, 6'o30};
    move_ready = 1'b1;
    pulse_capture();
    checks++;
    if ({move_valid, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL king_far_rejected: got v/busy/done=%b want 001", {move_valid, busy, done});
    end
    @(negedge clk);
    ray_tok[3] = {1'b1, 4'b0010, 6'o33};
    pulse_capture();
    checks++;
    if ({move_valid, move_from, move_piece, move_capture} !== {1'b1, 6'o33, 5'b10010, 1'b0}) begin
      errors++;
      $display("FAIL king_adjacent: got v=%0b from=%o piece=%b cap=%0b want 1 33 10010 0",
               move_valid, move_from, move_piece, move_capture);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL king_adjacent_done: got done=%0b want 1", done);
    end
    @(negedge clk);
    sq_piece = {1'b1, 5'b00001};
    pulse_capture();
    checks++;
    if ({move_valid, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL own_piece_zero_moves: got v/busy/done=%b want 001", {move_valid, busy, done});
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    clear_inputs();
    ray_tok[0] = {1'b1, 4'b1000, 6'o04};
    ray_tok[2] = {1'b1, 4'b1100, 6'o31};
    kn_tok[0]  = {1'b1, 1'b1, 6'o15};
    pulse_capture();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({move_valid, move_from, move_piece, busy, done} !== {1'b1, 6'o04, 5'b11000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%0b from=%o piece=%b busy=%0b done=%0b want 1 04 11000 1 0",
                 i, move_valid, move_from, move_piece, busy, done);
      end
      capture = (i == 1 || i == 3);
      if (i == 1) begin
        ray_tok[1] = {1'b1, 4'b1000, 6'o74};
        kn_tok[0]  = 8'd0;
      end
      @(negedge clk);
    end
    capture    = 1'b0;
    move_ready = 1'b1;
    checks++;
    if ({move_valid, move_from} !== {1'b1, 6'o04}) begin
      errors++;
      $display("FAIL stall_first: got v=%0b from=%o want 1 04", move_valid, move_from);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, move_from, move_piece} !== {1'b1, 6'o31, 5'b11100}) begin
      errors++;
      $display("FAIL stall_second: got v=%0b from=%o piece=%b want 1 31 11100",
               move_valid, move_from, move_piece);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, move_from, move_piece} !== {1'b1, 6'o15, 5'b10000}) begin
      errors++;
      $display("FAIL stall_third: got v=%0b from=%o piece=%b want 1 15 10000",
               move_valid, move_from, move_piece);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, done} !== 2'b01) begin
      errors++;
      $display("FAIL stall_done: got v/done=%b want 01", {move_valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    clear_inputs();
    ray_tok[0] = {1'b1, 4'b1000, 6'o04};
    ray_tok[2] = {1'b1, 4'b1100, 6'o31};
    kn_tok[0]  = {1'b1, 1'b1, 6'o15};
    move_ready = 1'b1;
    pulse_capture();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({move_valid, move_from, move_to, move_piece, move_capture, busy, done} !==
        {1'b0, 6'd0, TB_SQ, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h",
               {move_valid, move_from, move_to, move_piece, move_capture, busy, done},
               {1'b0, 6'd0, TB_SQ, 5'd0, 1'b0, 1'b0, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({move_valid, done} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_done[%0d]: got v/done=%b want 00", i, {move_valid, done});
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    clear_inputs();
    ray_tok[3] = {1'b1, 4'b1000, 6'o37};
    move_ready = 1'b1;
    pulse_capture();
    checks++;
    if ({move_valid, move_from, move_piece} !== {1'b1, 6'o37, 5'b11000}) begin
      errors++;
      $display("FAIL fresh_scan: got v=%0b from=%o piece=%b want 1 37 11000",
               move_valid, move_from, move_piece);
    end
    @(negedge clk);
    checks++;
    if ({move_valid, done} !== 2'b01) begin
      errors++;
      $display("FAIL fresh_scan_done: got v/done=%b want 01", {move_valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_black_all_white();
    clear_inputs();
    engine_color = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ray_tok[i] = {1'b1, 4'b1100, 6'($urandom)};
      kn_tok[i]  = {1'b1, 1'b1, 6'($urandom)};
    end
    move_ready = 1'b1;
    pulse_capture();
    checks++;
    if ({move_valid, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL black_all_white: got v/busy/done=%b want 001", {move_valid, busy, done});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int  cyc;
    bit  fin;
    for (int it = 0; it < 60; it++) begin
      engine_color = 1'($urandom);
      randomize_inputs();
      model_build();
      pulse_capture();
      randomize_inputs();
      cyc = 0;
      fin = 0;
      while (!fin) begin
        if (cyc > 300) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout[%0d]: %0d moves still expected", it, exp_q.size());
          fin = 1;
        end else if (exp_q.size() > 0) begin
          checks++;
          if ({move_valid, move_from, move_to, move_piece, move_capture, busy, done} !==
              {1'b1, exp_q[0].org, TB_SQ, exp_q[0].piece, exp_q[0].cap, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rand_move[%0d]: got v=%0b from=%o to=%o piece=%b cap=%0b busy=%0b done=%0b want 1 %o %o %b %0b 1 0",
                     it, move_valid, move_from, move_to, move_piece, move_capture, busy, done,
                     exp_q[0].org, TB_SQ, exp_q[0].piece, exp_q[0].cap);
          end
          move_ready = 1'($urandom);
          capture    = ($urandom_range(5) == 0);
          if (move_ready) void'(exp_q.pop_front());
          @(negedge clk);
          cyc++;
        end else begin
          checks++;
          if ({move_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL rand_done[%0d]: got v/busy/done=%b want 001", it, {move_valid, busy, done});
          end
          capture = 1'b0;
          fin = 1;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_rook_knight();
    test_pawn_capture();
    test_king();
    test_stall();
    test_reset_mid_scan();
    test_black_all_white();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
